// File: rtl/prime_pkg.sv
// Shared types for the RSA prime search sequencer: FSM states, Fermat bases,
// candidate conditioning and a product type wide enough for any supported WIDTH.
package prime_pkg;
  localparam int MAX_W          = 128;
  localparam int BASE_A_DEFAULT = 2;
  localparam int BASE_B         = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_COND, S_TEST, S_WAIT, S_STORE, S_MUL, S_DONE, S_FAIL
  } state_t;

  typedef logic [2*MAX_W-1:0] prod_t;

  // Force the MSB (full-size key) and LSB (odd) of a w-bit random word.
  function automatic logic [MAX_W-1:0] cond_mask(input logic [MAX_W-1:0] v, input int unsigned w);
    return v | (MAX_W'(1) << (w - 1)) | MAX_W'(1);
  endfunction
endpackage

// File: rtl/prime_search_ctrl_if.sv
// Random source and Fermat engine handshakes seen by the prime search sequencer.
interface prime_search_ctrl_if #(parameter int WIDTH = 64);
  logic [WIDTH-1:0] rng_value;
  logic             rng_step;
  logic             test_start;
  logic [WIDTH-1:0] test_n;
  logic [WIDTH-1:0] test_a;
  logic             test_done;
  logic             test_prime;

  modport master (output rng_step, test_start, test_n, test_a,
                  input  rng_value, test_done, test_prime);
  modport slave  (input  rng_step, test_start, test_n, test_a,
                  output rng_value, test_done, test_prime);
endinterface

// File: rtl/phi_mult.sv
// Shift-add unsigned WIDTH x WIDTH multiplier; done pulses exactly WIDTH cycles
// after start, with prod valid in that cycle.
module phi_mult #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= CW'(WIDTH);
      end else if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign prod = acc;
endmodule

// File: rtl/prime_search_ctrl.sv
// Finds two distinct probable primes p, q via the shared Fermat engine and computes phi.
// Optional MULTI_BASE_EN: retest each base-A survivor with base 3 before accepting it.
module prime_search_ctrl
  import prime_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_TRIES = 4096,
  parameter int BASE_A    = BASE_A_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  prime_search_ctrl_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [WIDTH-1:0]    p,
  output logic [WIDTH-1:0]    q,
  output logic [2*WIDTH-1:0]  phi
);
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0] TRY_LIMIT = CW'(MAX_TRIES);

  state_t             state;
  logic [WIDTH-1:0]   cand;
  logic [CW-1:0]      tries;
  logic               target_q;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   cand_c;
  logic [CW-1:0]      tries_inc;
`ifdef MULTI_BASE_EN
  logic               second_pass;
`endif

  assign cand_c    = WIDTH'(cond_mask(MAX_W'(bus.rng_value), WIDTH));
  assign tries_inc = tries + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cand           <= '0;
      tries          <= '0;
      target_q       <= 1'b0;
      mul_start      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      p              <= '0;
      q              <= '0;
      phi            <= '0;
      bus.rng_step   <= 1'b0;
      bus.test_start <= 1'b0;
      bus.test_n     <= '0;
      bus.test_a     <= '0;
`ifdef MULTI_BASE_EN
      second_pass    <= 1'b0;
`endif
    end else begin
      bus.rng_step   <= 1'b0;
      bus.test_start <= 1'b0;
      mul_start      <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            p            <= '0;
            q            <= '0;
            phi          <= '0;
            done         <= 1'b0;
            fail         <= 1'b0;
            tries        <= '0;
            target_q     <= 1'b0;
            busy         <= 1'b1;
            bus.rng_step <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_FETCH: state <= S_COND;
        S_COND: begin
          cand  <= cand_c;
          tries <= tries_inc;
          // A repeat of p is thrown away without spending engine time on it.
          if (target_q && cand_c == p) begin
            if (tries_inc >= TRY_LIMIT) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FAIL;
            end else begin
              bus.rng_step <= 1'b1;
              state        <= S_FETCH;
            end
          end else begin
            bus.test_n     <= cand_c;
            bus.test_a     <= WIDTH'(BASE_A);
            bus.test_start <= 1'b1;
`ifdef MULTI_BASE_EN
            second_pass    <= 1'b0;
`endif
            state          <= S_TEST;
          end
        end
        S_TEST: state <= S_WAIT;
        S_WAIT: begin
          if (bus.test_done) begin
            if (bus.test_prime) begin
`ifdef MULTI_BASE_EN
              if (!second_pass) begin
                second_pass    <= 1'b1;
                bus.test_a     <= WIDTH'(BASE_B);
                bus.test_start <= 1'b1;
                state          <= S_TEST;
              end else begin
                state <= S_STORE;
              end
`else
              state <= S_STORE;
`endif
            end else if (tries >= TRY_LIMIT) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FAIL;
            end else begin
              bus.rng_step <= 1'b1;
              state        <= S_FETCH;
            end
          end
        end
        S_STORE: begin
          if (!target_q) begin
            p            <= cand;
            tries        <= '0;
            target_q     <= 1'b1;
            bus.rng_step <= 1'b1;
            state        <= S_FETCH;
          end else begin
            q         <= cand;
            mul_start <= 1'b1;
            state     <= S_MUL;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            phi   <= mul_prod;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  phi_mult #(.WIDTH(WIDTH)) u_phi_mult (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (p - 1'b1),
    .b     (q - 1'b1),
    .done  (mul_done),
    .prod  (mul_prod)
  );
endmodule
